// File: rtl/mc_hazard_ctrl_pkg.sv
// rtl/mc_hazard_ctrl_pkg.sv - shared slot record and register-match rule for multi-cycle hazard control
package mc_hazard_ctrl_pkg;

    // Counter field is sized for the widest supported latency; LAT_W must not exceed CNT_W.
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic             fp;
        logic [CNT_W-1:0] cnt;
    } mc_slot_t;

    // Integer x0 never carries a dependency; FP f0 is a real register.
    function automatic logic reg_match(input logic [4:0] idx, input logic fp, input mc_slot_t slot);
        return slot.valid && (slot.rd == idx) && (slot.fp == fp) && (fp || (idx != 5'd0));
    endfunction

endpackage

// File: rtl/mc_slot_arb.sv
// rtl/mc_slot_arb.sv - lowest-index-first priority encoder over slot requests
module mc_slot_arb #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    output logic         gnt_any,
    output logic [W-1:0] gnt_idx
);

    always_comb begin
        gnt_any = |req;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/mc_hazard_ctrl.sv
// rtl/mc_hazard_ctrl.sv - multi-cycle op scoreboard, decode stall generation and write-port arbitration
module mc_hazard_ctrl
    import mc_hazard_ctrl_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter int  LAT_W  = 5,
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid,
    input  logic              flush_i,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rs3,
    input  logic              id_rs1_fp,
    input  logic              id_rs2_fp,
    input  logic              id_rs3_fp,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_rs3_used,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_fp,
    input  logic              id_wb_n,
    input  logic              id_mc_op,
    input  logic [LAT_W-1:0]  id_mc_lat,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rd,
    input  logic              idex_rd_fp,
    input  logic              memwb_wb_n,
    output logic              stall_id,
    output logic              mc_issue,
    output logic [SLOT_W-1:0] mc_slot,
    output logic              wb_sel,
    output logic [SLOT_W-1:0] wb_slot,
    output logic [4:0]        wb_rd,
    output logic              wb_rd_fp,
    output logic              wb_hold
);

    mc_slot_t          slots [DEPTH];
    logic [DEPTH-1:0]  free_vec;
    logic [DEPTH-1:0]  ready_vec;
    logic              free_any;
    logic              ready_any;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W-1:0] ready_idx;
    logic              raw;
    logic              waw;
    logic              loaduse;
    logic              full;
    logic              hazard;
    logic              active;
    mc_slot_t          ex_slot;
    logic [CNT_W-1:0]  issue_cnt;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i]  = !slots[i].valid;
            ready_vec[i] = slots[i].valid && (slots[i].cnt == CNT_W'(1));
        end
    end

    mc_slot_arb #(.N(DEPTH), .W(SLOT_W)) u_free_arb (
        .req     (free_vec),
        .gnt_any (free_any),
        .gnt_idx (free_idx)
    );

    mc_slot_arb #(.N(DEPTH), .W(SLOT_W)) u_ready_arb (
        .req     (ready_vec),
        .gnt_any (ready_any),
        .gnt_idx (ready_idx)
    );

    // The EX-stage load is treated as a one-entry pending slot so the same match rule applies.
    always_comb begin
        ex_slot = '{valid: idex_mem_read, rd: idex_rd, fp: idex_rd_fp, cnt: '0};
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            raw = raw | (id_rs1_used && reg_match(id_rs1, id_rs1_fp, slots[i]))
                      | (id_rs2_used && reg_match(id_rs2, id_rs2_fp, slots[i]))
                      | (id_rs3_used && reg_match(id_rs3, id_rs3_fp, slots[i]));
            waw = waw | (!id_wb_n && reg_match(id_rd, id_rd_fp, slots[i]));
        end
        loaduse = (id_rs1_used && reg_match(id_rs1, id_rs1_fp, ex_slot))
                | (id_rs2_used && reg_match(id_rs2, id_rs2_fp, ex_slot))
                | (id_rs3_used && reg_match(id_rs3, id_rs3_fp, ex_slot));
        full    = id_mc_op && !free_any;
        hazard  = raw || waw || loaduse || full;
        active  = id_valid && !flush_i && !reset_i;

        stall_id  = active && hazard;
        mc_issue  = active && id_mc_op && !hazard;
        mc_slot   = reset_i ? '0 : free_idx;
        issue_cnt = (id_mc_lat == '0) ? CNT_W'(1) : CNT_W'(id_mc_lat);

        wb_sel   = !reset_i && ready_any;
        wb_slot  = wb_sel ? ready_idx : '0;
        wb_rd    = wb_sel ? slots[ready_idx].rd : 5'd0;
        wb_rd_fp = wb_sel ? slots[ready_idx].fp : 1'b0;
        wb_hold  = wb_sel && !memwb_wb_n;
    end

    // Ready slots that lose arbitration sit at cnt==1 until granted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_sel && (wb_slot == SLOT_W'(i))) begin
                    slots[i].valid <= 1'b0;
                end else if (slots[i].valid && (slots[i].cnt > CNT_W'(1))) begin
                    slots[i].cnt <= slots[i].cnt - CNT_W'(1);
                end
                if (mc_issue && (mc_slot == SLOT_W'(i))) begin
                    slots[i] <= '{valid: 1'b1, rd: id_rd, fp: id_rd_fp, cnt: issue_cnt};
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_hazard_ctrl.sv
// tb/tb_mc_hazard_ctrl.sv - self-checking bench for mc_hazard_ctrl against a due-time reference model
module tb_mc_hazard_ctrl;
    localparam int DEPTH = 2;
    localparam int LAT_W = 5;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             id_valid, flush_i;
    logic [4:0]       id_rs1, id_rs2, id_rs3, id_rd, idex_rd;
    logic             id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rd_fp, idex_rd_fp;
    logic             id_rs1_used, id_rs2_used, id_rs3_used;
    logic             id_wb_n, id_mc_op, idex_mem_read, memwb_wb_n;
    logic [LAT_W-1:0] id_mc_lat;
    logic             stall_id, mc_issue, wb_sel, wb_rd_fp, wb_hold;
    logic [0:0]       mc_slot, wb_slot;
    logic [4:0]       wb_rd;

    always #5 clk_i = ~clk_i;

    mc_hazard_ctrl #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .id_valid(id_valid), .flush_i(flush_i),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_rs3_fp(id_rs3_fp),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rs3_used(id_rs3_used),
        .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_wb_n(id_wb_n), .id_mc_op(id_mc_op),
        .id_mc_lat(id_mc_lat), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .idex_rd_fp(idex_rd_fp), .memwb_wb_n(memwb_wb_n), .stall_id(stall_id),
        .mc_issue(mc_issue), .mc_slot(mc_slot), .wb_sel(wb_sel), .wb_slot(wb_slot),
        .wb_rd(wb_rd), .wb_rd_fp(wb_rd_fp), .wb_hold(wb_hold)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: each pending op remembers the absolute cycle from which it may write back.
    bit m_valid [DEPTH];
    int m_rd    [DEPTH];
    bit m_fp    [DEPTH];
    int m_due   [DEPTH];

    bit e_stall, e_issue, e_wb_sel;
    int e_slot, e_wb_slot;
    bit last_stall, last_issue;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit pend(input int idx, input bit fp);
        if (!fp && idx == 0) return 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_rd[i] == idx && m_fp[i] == fp) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ex_dep(input bit used, input int idx, input bit fp);
        return used && idex_mem_read && idx == int'(idex_rd) && fp == idex_rd_fp && (fp || idx != 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        bit hz;
        #3;
        e_stall = 0; e_issue = 0; e_wb_sel = 0; e_wb_slot = 0; e_slot = -1;
        if (reset_i) begin
            model_clear();
            check("rst_stall", 8'(stall_id), 8'd0);
            check("rst_issue", 8'(mc_issue), 8'd0);
            check("rst_mc_slot", 8'(mc_slot), 8'd0);
            check("rst_wb_sel", 8'(wb_sel), 8'd0);
            check("rst_wb_slot", 8'(wb_slot), 8'd0);
            check("rst_wb_rd", 8'(wb_rd), 8'd0);
            check("rst_wb_rd_fp", 8'(wb_rd_fp), 8'd0);
            check("rst_wb_hold", 8'(wb_hold), 8'd0);
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (!e_wb_sel && m_valid[i] && cyc >= m_due[i]) begin
                    e_wb_sel = 1; e_wb_slot = i;
                end
            for (int i = 0; i < DEPTH; i++)
                if (e_slot < 0 && !m_valid[i]) e_slot = i;
            hz = (id_rs1_used && pend(int'(id_rs1), id_rs1_fp))
              || (id_rs2_used && pend(int'(id_rs2), id_rs2_fp))
              || (id_rs3_used && pend(int'(id_rs3), id_rs3_fp))
              || (!id_wb_n && pend(int'(id_rd), id_rd_fp))
              || ex_dep(id_rs1_used, int'(id_rs1), id_rs1_fp)
              || ex_dep(id_rs2_used, int'(id_rs2), id_rs2_fp)
              || ex_dep(id_rs3_used, int'(id_rs3), id_rs3_fp)
              || (id_mc_op && e_slot < 0);
            e_stall = id_valid && !flush_i && hz;
            e_issue = id_valid && !flush_i && id_mc_op && !hz;
            check("stall_id", 8'(stall_id), 8'(e_stall));
            check("mc_issue", 8'(mc_issue), 8'(e_issue));
            if (e_issue) check("mc_slot", 8'(mc_slot), 8'(e_slot));
            check("wb_sel", 8'(wb_sel), 8'(e_wb_sel));
            check("wb_hold", 8'(wb_hold), 8'(e_wb_sel && !memwb_wb_n));
            if (e_wb_sel) begin
                check("wb_slot", 8'(wb_slot), 8'(e_wb_slot));
                check("wb_rd", 8'(wb_rd), 8'(m_rd[e_wb_slot]));
                check("wb_rd_fp", 8'(wb_rd_fp), 8'(m_fp[e_wb_slot]));
            end
        end
        last_stall = stall_id;
        last_issue = mc_issue;
        @(posedge clk_i);
        if (reset_i) begin
            model_clear();
        end else begin
            if (e_wb_sel) m_valid[e_wb_slot] = 1'b0;
            if (e_issue) begin
                m_valid[e_slot] = 1'b1;
                m_rd[e_slot]    = int'(id_rd);
                m_fp[e_slot]    = id_rd_fp;
                m_due[e_slot]   = cyc + ((id_mc_lat == 0) ? 1 : int'(id_mc_lat));
            end
        end
        cyc++;
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; flush_i = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs3 = 0;
        id_rs1_fp = 0; id_rs2_fp = 0; id_rs3_fp = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rs3_used = 0;
        id_rd = 0; id_rd_fp = 0; id_wb_n = 1; id_mc_op = 0; id_mc_lat = 0;
        idex_mem_read = 0; idex_rd = 0; idex_rd_fp = 0;
    endtask

    task automatic id_mc(input int rd, input bit fp, input int lat);
        id_clear();
        id_valid = 1; id_rd = 5'(rd); id_rd_fp = fp; id_wb_n = 0;
        id_mc_op = 1; id_mc_lat = LAT_W'(lat);
    endtask

    task automatic id_read(input int rs, input bit fp);
        id_clear();
        id_valid = 1; id_rs1 = 5'(rs); id_rs1_fp = fp; id_rs1_used = 1;
    endtask

    initial begin
        int stall_cnt;
        int guard;
        model_clear();
        id_clear();
        memwb_wb_n = 1;
        reset_i = 1;
        #1;
        tick();
        tick();
        reset_i = 0;

        // FP div to f5 (lat 4), dependent read stalls exactly four cycles
        id_mc(5, 1, 4);
        tick();
        stall_cnt = 0;
        guard = 0;
        do begin
            id_read(5, 1);
            tick();
            if (last_stall) stall_cnt++;
            guard++;
        end while (last_stall && guard < 10);
        check("s1_stall_cycles", 8'(stall_cnt), 8'd4);

        // load-use on x7 then on x0
        id_read(7, 0); idex_mem_read = 1; idex_rd = 7;
        tick();
        id_read(7, 0);
        tick();
        id_read(0, 0); idex_mem_read = 1; idex_rd = 0;
        tick();

        // pending f0: integer x0 read is free, f0 read stalls until writeback
        id_mc(0, 1, 3);
        tick();
        id_read(0, 0);
        tick();
        guard = 0;
        do begin
            id_read(0, 1);
            tick();
            guard++;
        end while (last_stall && guard < 10);

        // fill both slots, third multi-cycle op waits on full
        id_mc(1, 0, 3);
        tick();
        id_mc(2, 0, 5);
        tick();
        guard = 0;
        do begin
            id_mc(3, 0, 2);
            tick();
            guard++;
        end while (!last_issue && guard < 15);
        check("s4_third_issued", 8'(last_issue), 8'd1);
        id_clear();
        repeat (8) tick();

        // two slots ready together while MEM/WB owns the port
        memwb_wb_n = 0;
        id_mc(8, 0, 3);
        tick();
        id_mc(9, 1, 2);
        tick();
        id_clear();
        repeat (4) tick();
        memwb_wb_n = 1;

        // reset in the middle of a countdown
        id_mc(4, 0, 6);
        tick();
        id_clear();
        tick();
        reset_i = 1;
        tick();
        reset_i = 0;
        repeat (8) tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 7) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs3      = 5'($urandom_range(0, 3));
            id_rs1_fp   = 1'($urandom_range(0, 1));
            id_rs2_fp   = 1'($urandom_range(0, 1));
            id_rs3_fp   = 1'($urandom_range(0, 1));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rs3_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 3));
            id_rd_fp    = 1'($urandom_range(0, 1));
            id_wb_n     = 1'($urandom_range(0, 1));
            id_mc_op    = ($urandom_range(0, 2) == 0);
            id_mc_lat   = LAT_W'($urandom_range(0, 6));
            idex_mem_read = ($urandom_range(0, 3) == 0);
            idex_rd     = 5'($urandom_range(0, 3));
            idex_rd_fp  = 1'($urandom_range(0, 1));
            memwb_wb_n  = 1'($urandom_range(0, 1));
            reset_i     = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
